// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage register with optional skid entry, flush, stall and drop counter
// M always drives the output directly; S (SKID=1 only) catches the beat in flight when downstream stops.
module pipe_stage_skid #(
  parameter int             DW               = 160,
  parameter logic [DW-1:0]  NOP_VAL          = {DW{1'b0}},
  parameter bit             SKID             = 1'b1,
  parameter bit             FLUSH_OVER_STALL = 1'b1,
  parameter int             CW               = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          stall_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [1:0]    occ_o,
  output logic [CW-1:0] drop_cnt_o
);

  localparam logic [1:0]    ST_EMPTY = 2'd0;
  localparam logic [1:0]    ST_ONE   = 2'd1;
  localparam logic [1:0]    ST_FULL  = 2'd2;
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic [1:0]    r_state;
  logic [DW-1:0] r_m;
  logic [DW-1:0] r_s;
  logic [CW-1:0] r_drop;

  logic          w_ready;
  logic          w_acc;
  logic          w_pop;
  logic          w_flush;
  logic [CW:0]   w_occ_ext;
  logic [CW:0]   w_drop_sum;
  logic [CW-1:0] w_drop_next;

  // With SKID the ready is a pure state decode, cutting the out_ready_i -> in_ready_o path.
  always_comb begin
    w_ready = 1'b0;
    if (SKID) begin
      w_ready = (r_state != ST_FULL) & ~stall_i;
    end else begin
      w_ready = ((r_state == ST_EMPTY) | (out_ready_i & ~stall_i)) & ~stall_i;
    end
  end

  assign w_acc   = in_valid_i & w_ready;
  assign w_pop   = out_valid_o & out_ready_i & ~stall_i;
  assign w_flush = flush_i & (FLUSH_OVER_STALL | ~stall_i);

  // Killed entries are counted from the current occupancy, saturating at all-ones.
  always_comb begin
    w_occ_ext      = '0;
    w_occ_ext[1:0] = r_state;
    w_drop_sum     = {1'b0, r_drop} + w_occ_ext;
    w_drop_next    = (w_drop_sum > {1'b0, CNT_MAX}) ? CNT_MAX : w_drop_sum[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
      r_m     <= NOP_VAL;
      r_s     <= NOP_VAL;
      r_drop  <= '0;
    end else if (w_flush) begin
      r_state <= ST_EMPTY;
      r_m     <= NOP_VAL;
      r_s     <= NOP_VAL;
      r_drop  <= w_drop_next;
    end else begin
      // Stall forces acc and pop low, so every branch below holds under stall.
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_state <= ST_ONE;
            r_m     <= in_data_i;
          end
        end
        ST_ONE: begin
          if (w_acc && w_pop) begin
            r_m <= in_data_i;
          end else if (w_acc && SKID) begin
            r_state <= ST_FULL;
            r_s     <= in_data_i;
          end else if (w_pop) begin
            r_state <= ST_EMPTY;
            r_m     <= NOP_VAL;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            r_state <= ST_ONE;
            r_m     <= r_s;
            r_s     <= NOP_VAL;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_m     <= NOP_VAL;
          r_s     <= NOP_VAL;
        end
      endcase
    end
  end

  assign in_ready_o  = w_ready;
  assign out_valid_o = (r_state != ST_EMPTY);
  assign out_data_o  = r_m;
  assign occ_o       = r_state;
  assign drop_cnt_o  = r_drop;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - bench for pipe_stage_skid over three configurations sharing one stimulus
// dut_a: SKID=1 flush-over-stall CW=2 (scoreboarded stream); dut_b: stall-over-flush; dut_c: SKID=0.
module tb_pipe_stage_skid;

  localparam int         DW    = 8;
  localparam logic [7:0] NOP_A = 8'hEE;
  localparam logic [7:0] NOP_C = 8'hA5;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          stall;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          a_in_ready, a_out_valid;
  logic [DW-1:0] a_out_data;
  logic [1:0]    a_occ;
  logic [1:0]    a_drop;

  logic          b_in_ready, b_out_valid;
  logic [DW-1:0] b_out_data;
  logic [1:0]    b_occ;
  logic [3:0]    b_drop;

  logic          c_in_ready, c_out_valid;
  logic [DW-1:0] c_out_data;
  logic [1:0]    c_occ;
  logic [3:0]    c_drop;

  int checks;
  int failures;
  logic [DW-1:0] exp_q[$];

  pipe_stage_skid #(.DW(DW), .NOP_VAL(NOP_A), .SKID(1'b1), .FLUSH_OVER_STALL(1'b1), .CW(2)) dut_a (
    .clk(clk), .rst(rst), .flush_i(flush), .stall_i(stall),
    .in_valid_i(in_valid), .in_ready_o(a_in_ready), .in_data_i(in_data),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready), .out_data_o(a_out_data),
    .occ_o(a_occ), .drop_cnt_o(a_drop)
  );

  pipe_stage_skid #(.DW(DW), .NOP_VAL(NOP_A), .SKID(1'b1), .FLUSH_OVER_STALL(1'b0), .CW(4)) dut_b (
    .clk(clk), .rst(rst), .flush_i(flush), .stall_i(stall),
    .in_valid_i(in_valid), .in_ready_o(b_in_ready), .in_data_i(in_data),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready), .out_data_o(b_out_data),
    .occ_o(b_occ), .drop_cnt_o(b_drop)
  );

  pipe_stage_skid #(.DW(DW), .NOP_VAL(NOP_C), .SKID(1'b0), .FLUSH_OVER_STALL(1'b1), .CW(4)) dut_c (
    .clk(clk), .rst(rst), .flush_i(flush), .stall_i(stall),
    .in_valid_i(in_valid), .in_ready_o(c_in_ready), .in_data_i(in_data),
    .out_valid_o(c_out_valid), .out_ready_i(out_ready), .out_data_o(c_out_data),
    .occ_o(c_occ), .drop_cnt_o(c_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Handshakes are judged at the falling edge, half a cycle before the edge that completes them.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst && a_out_valid && out_ready && !stall && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stream_extra actual=%0h required=none", a_out_data);
        end else begin
          chk("stream_data", int'(a_out_data), int'(exp_q.pop_front()));
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic fill_and_flush(input int exp_drop);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    cyc();
    in_data   = 8'h22;
    cyc();
    chk("flush_pre_occ", int'(a_occ), 2);
    flush   = 1'b1;
    in_data = 8'h33;
    cyc();
    chk("flush_valid", int'(a_out_valid), 0);
    chk("flush_data", int'(a_out_data), int'(NOP_A));
    chk("flush_drop", int'(a_drop), exp_drop);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("flush_beat_killed", int'(a_out_valid), 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    fork
      monitor();
    join_none

    do_reset();
    rst = 1'b0;
    cyc();
    chk("rst_valid", int'(a_out_valid), 0);
    chk("rst_data", int'(a_out_data), int'(NOP_A));
    chk("rst_occ", int'(a_occ), 0);
    chk("rst_drop", int'(a_drop), 0);
    chk("rst_ready", int'(a_in_ready), 1);
    stall = 1'b1;
    #1;
    chk("rst_ready_stall", int'(a_in_ready), 0);
    stall = 1'b0;
    rst   = 1'b1;
    cyc();

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      exp_q.push_back(8'(i));
      cyc();
      chk("stream_occ", int'(a_occ), 1);
    end
    in_valid = 1'b0;
    cyc();
    chk("stream_drain_occ", int'(a_occ), 0);

    // Back-pressure for three cycles, then release.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h0A;
    exp_q.push_back(8'h0A);
    #1;
    chk("bp_ready_a", int'(a_in_ready), 1);
    cyc();
    in_data = 8'h0B;
    exp_q.push_back(8'h0B);
    #1;
    chk("bp_ready_b", int'(a_in_ready), 1);
    cyc();
    chk("bp_occ_full", int'(a_occ), 2);
    in_data = 8'h0C;
    #1;
    chk("bp_ready_c", int'(a_in_ready), 0);
    cyc();
    chk("bp_occ_hold", int'(a_occ), 2);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_pop_cycle", int'(a_in_ready), 0);
    cyc();
    chk("bp_ready_recover", int'(a_in_ready), 1);
    exp_q.push_back(8'h0C);
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("bp_drain_occ", int'(a_occ), 0);

    // Flush at FULL, then saturation of the 2-bit counter.
    fill_and_flush(2);
    fill_and_flush(3);
    fill_and_flush(3);

    // Stall together with flush at occupancy 1.
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h44;
    cyc();
    in_valid = 1'b0;
    stall    = 1'b1;
    flush    = 1'b1;
    #1;
    chk("sf_ready_stalled", int'(a_in_ready), 0);
    chk("sf_b_valid", int'(b_out_valid), 1);
    cyc();
    chk("sf_a_occ", int'(a_occ), 0);
    chk("sf_a_drop", int'(a_drop), 1);
    chk("sf_b_occ", int'(b_occ), 1);
    chk("sf_b_drop", int'(b_drop), 0);
    chk("sf_b_data", int'(b_out_data), 8'h44);
    flush     = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("stall_b_occ", int'(b_occ), 1);
    chk("stall_b_data", int'(b_out_data), 8'h44);
    stall     = 1'b0;
    out_ready = 1'b0;

    // SKID=0 pass-through and reset mid-stream.
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h55;
    exp_q.push_back(8'h55);
    #1;
    chk("p0_ready_empty", int'(c_in_ready), 1);
    cyc();
    chk("p0_occ", int'(c_occ), 1);
    out_ready = 1'b1;
    in_data   = 8'h66;
    #1;
    chk("p0_ready_pass", int'(c_in_ready), 1);
    cyc();
    chk("p0_replace_data", int'(c_out_data), 8'h66);
    chk("p0_replace_occ", int'(c_occ), 1);
    out_ready = 1'b0;
    in_data   = 8'h77;
    #1;
    chk("p0_ready_blocked", int'(c_in_ready), 0);
    cyc();
    chk("p0_hold_data", int'(c_out_data), 8'h66);
    rst       = 1'b0;
    in_data   = 8'h88;
    out_ready = 1'b1;
    cyc();
    chk("p0_rst_valid", int'(c_out_valid), 0);
    chk("p0_rst_data", int'(c_out_data), int'(NOP_C));
    chk("p0_rst_occ", int'(c_occ), 0);
    chk("p0_rst_drop", int'(c_drop), 0);
    chk("p0_rst_ready", int'(c_in_ready), 1);
    chk("p0_rst_a_occ", int'(a_occ), 0);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cyc();
    cyc();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush, external stall, and NOP-bubble injection. It is the next-generation stage register between any two core pipeline stages (IF/ID, ID/EX, EX/MEM). The payload is one opaque DW-bit vector that the instantiating stage packs. It adds back-pressure and a saturating count of killed entries.

## Interface
- DW, 160: payload width in bits (≥1).
- NOP_VAL, {DW{1'b0}}: payload value driven when the stage is empty, after reset and after flush.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready_o; 0 = single entry with combinational ready pass-through.
- FLUSH_OVER_STALL, 1: 1 = flush_i wins over stall_i; 0 = stall_i wins and the flush is ignored that cycle.
- CW, 16: width of the drop counter.
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- flush_i  in  1  kill all held entries this cycle.
- stall_i  in  1  freeze the stage; no accept, no pop.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept.
- in_data_i  in  DW  upstream payload.
- out_valid_o  out  1  M holds a live entry.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  DW  payload; equals NOP_VAL when not valid.
- occ_o  out  2  occupancy, 0..2 (0..1 when SKID=0).
- drop_cnt_o  out  CW  saturating count of entries killed by flush.

## Operation
- Storage: main register M drives out_data_o directly. Skid register S exists only when SKID=1. State is EMPTY, ONE or FULL, and occ_o encodes it as 0/1/2.
- Events:
  - acc = in_valid_i & in_ready_o.
  - pop = out_valid_o & out_ready_i & ~stall_i.
- Ready:
  - SKID=1: in_ready_o = (state != FULL) & ~stall_i. This is decoded from the state flop, so there is no path from out_ready_i.
  - SKID=0: in_ready_o = ((state == EMPTY) | (out_ready_i & ~stall_i)) & ~stall_i.
- out_valid_o = (state != EMPTY).
- Transitions, evaluated when there is no effective flush:
  - EMPTY: acc → ONE, M←in_data_i.
  - ONE, acc & ~pop: SKID=1 → FULL, S←in_data_i. SKID=0 cannot occur.
  - ONE, acc & pop: stays ONE, M←in_data_i.
  - ONE, ~acc & pop: → EMPTY, M←NOP_VAL.
  - ONE, no event: hold.
  - FULL: acc is impossible. pop → ONE, M←S, S←NOP_VAL. Otherwise hold.
- Stall (stall_i=1): all state, M, S and drop_cnt_o hold. in_ready_o=0. Downstream still sees out_valid_o/out_data_o unchanged.
- Effective flush = flush_i & (FLUSH_OVER_STALL | ~stall_i). On effective flush:
  - state→EMPTY; M and S←NOP_VAL.
  - Any same-cycle acc is discarded; in_ready_o is not masked, so the upstream treats the beat as consumed-and-killed.
  - drop_cnt_o ← min(drop_cnt_o + occ_o, 2^CW−1). A same-cycle pop is still counted as dropped.
- Reset (rst=0): state EMPTY, M=S=NOP_VAL, drop_cnt_o=0. Reset overrides flush and stall.
- Reset outputs: out_valid_o=0, out_data_o=NOP_VAL, occ_o=0, drop_cnt_o=0. in_ready_o=~stall_i (combinational).

## Timing
- Latency: a beat accepted at edge N appears on out_data_o after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle when out_ready_i=1.
- SKID=1, back-pressure: out_ready_i dropping costs no beat, because S absorbs the in-flight one. in_ready_o falls one cycle after out_ready_i falls, and only if an accept occurred that cycle.
- SKID=1, recovery: from FULL with pop, in_ready_o rises the cycle after the pop edge.
- Ordering: FIFO; S is never output ahead of M.
- Saturation: drop_cnt_o holds at 2^CW−1 and never wraps.
- Reset mid-operation: held entries are lost without being counted.

## Test plan
- Streaming: SKID=1, out_ready_i=1, beats 0x1..0x8 on consecutive cycles → out_data_o shows 0x1..0x8 one cycle later, no gaps, occ_o=1 throughout.
- Back-pressure: hold out_ready_i=0 for 3 cycles while in_valid_i=1 with 0xA,0xB,0xC → 0xA,0xB accepted, occ_o=2, in_ready_o=0. Release → outputs 0xA,0xB,0xC in order, none lost or duplicated.
- Flush at FULL: flush_i=1 with occ_o=2 → next cycle out_valid_o=0, out_data_o=NOP_VAL, drop_cnt_o +2. A beat presented that same cycle is not output.
- Stall vs flush: stall_i=1 and flush_i=1 with occ_o=1. FLUSH_OVER_STALL=1 → EMPTY, drop_cnt_o=1. FLUSH_OVER_STALL=0 → holds, occ_o=1, drop_cnt_o=0.
- Saturation: CW=2, three flushes of occ 2 → drop_cnt_o = 2, 3, 3.
- SKID=0 pass-through: occ_o=1, out_ready_i=1, in_valid_i=1 → in_ready_o=1 in the same cycle and M is replaced. With out_ready_i=0 → in_ready_o=0. Reset asserted mid-stream → all outputs at their reset values next cycle.
